ex_muldiv: RTL

Multiply/divide unit and HI/LO register file for the EX stage; consumes the mult/div/HI-LO control fields that the ID/EX segment register presents (`ex_mult`, `ex_div`, `ex_mdsign`, `ex_hiloren`, `ex_hilowen`, `ex_A`, `ex_B`). It runs a 32-iteration radix-2 restoring divider and a registered 32x32 multiplier, and holds the pipeline with `md_stall` while an operation is in flight. It commits HI/LO when the instruction leaves EX and serves MFHI/MFLO reads combinationally.

---
 rtl/md_pkg.sv | 23 ++
 rtl/ex_muldiv_if.sv | 28 ++
 rtl/ex_div_core.sv | 55 +++++
 rtl/ex_muldiv.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam int          MD_DIV_ITER   = 32;
  localparam logic [31:0] MD_DIVZERO_LO = 32'hFFFF_FFFF;

  // Magnitude of v when treated as signed; pass-through for unsigned ops.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  function automatic logic [31:0] md_neg_if(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX mult/div/HI-LO control fields and the unit's results, as one bundle.
interface ex_muldiv_if;
  logic        ex_mult;
  logic        ex_div;
  logic        ex_mdsign;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [1:0]  ex_hiloren;
  logic [1:0]  ex_hilowen;
  logic        ex_cancel;
  logic        ex_advance;
  logic        md_stall;
  logic [31:0] hilo_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output ex_mult, ex_div, ex_mdsign, ex_A, ex_B, ex_hiloren, ex_hilowen,
           ex_cancel, ex_advance,
    input  md_stall, hilo_rdata, hi, lo
  );

  modport slave (
    input  ex_mult, ex_div, ex_mdsign, ex_A, ex_B, ex_hiloren, ex_hilowen,
           ex_cancel, ex_advance,
    output md_stall, hilo_rdata, hi, lo
  );
endinterface

// File: rtl/ex_div_core.sv
// Unsigned radix-2 restoring divider datapath: one quotient bit per step.
// Outputs are the post-step values so the caller can capture the final step.
module ex_div_core
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient_next,
  output logic [31:0] remainder_next,
  output logic        last
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic [4:0]  cnt_q;

  logic [32:0] partial;
  logic [31:0] trial;
  logic        fits;

  // The dividend is held in the quotient register and shifted out MSB first
  // while quotient bits shift in at the bottom.
  assign partial        = {rem_q, quo_q[31]};
  assign trial          = partial[31:0] - dsr_q;
  assign fits           = partial >= {1'b0, dsr_q};
  assign remainder_next = fits ? trial : partial[31:0];
  assign quotient_next  = {quo_q[30:0], fits};
  assign last           = (cnt_q == 5'(MD_DIV_ITER - 1));

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= remainder_next;
      quo_q <= quotient_next;
      cnt_q <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with architectural HI/LO.
// Define MD_MULT_1CYC_EN for a single-cycle combinational multiplier.
module ex_muldiv
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  ex_muldiv_if.slave  md
);

  md_state_e   state_q, state_d;

  logic        div_start, div_step, div_finish;
  logic        mul_load, hilo_commit, mthilo_wr;
  logic        mul_direct_wr;

  logic [63:0] a_ext, b_ext, product;
  logic [31:0] res_hi_q, res_lo_q;
  logic [31:0] hi_q, lo_q;
  logic        q_neg_q, r_neg_q, div_zero_q;
  logic [31:0] a_raw_q;

  logic [31:0] div_quo, div_rem;
  logic        div_last;

  // Sign-extending both operands to 64 bits lets one multiplier serve both
  // MULT and MULTU; the low 64 product bits are exact in either case.
  assign a_ext   = {{32{md.ex_mdsign & md.ex_A[31]}}, md.ex_A};
  assign b_ext   = {{32{md.ex_mdsign & md.ex_B[31]}}, md.ex_B};
  assign product = a_ext * b_ext;

  ex_div_core u_div_core (
    .clk            (clk),
    .reset          (reset),
    .start          (div_start),
    .step           (div_step),
    .dividend       (md_abs(md.ex_A, md.ex_mdsign)),
    .divisor        (md_abs(md.ex_B, md.ex_mdsign)),
    .quotient_next  (div_quo),
    .remainder_next (div_rem),
    .last           (div_last)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    md.md_stall   = 1'b0;
    div_start     = 1'b0;
    div_step      = 1'b0;
    div_finish    = 1'b0;
    mul_load      = 1'b0;
    mul_direct_wr = 1'b0;
    hilo_commit   = 1'b0;
    mthilo_wr     = 1'b0;

    if (md.ex_cancel) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (md.ex_div) begin
            div_start   = 1'b1;
            md.md_stall = 1'b1;
            state_d     = DIV;
          end else if (md.ex_mult) begin
`ifdef MD_MULT_1CYC_EN
            mul_direct_wr = md.ex_advance;
`else
            mul_load    = 1'b1;
            md.md_stall = 1'b1;
            state_d     = MUL;
`endif
          end else if (md.ex_hilowen != 2'b00) begin
            mthilo_wr = md.ex_advance;
          end
        end
`ifndef MD_MULT_1CYC_EN
        MUL: begin
          md.md_stall = 1'b1;
          state_d     = DONE;
        end
`endif
        DIV: begin
          md.md_stall = 1'b1;
          div_step    = 1'b1;
          if (div_last) begin
            div_finish = 1'b1;
            state_d    = DONE;
          end
        end
        DONE: begin
          // Hold the result until the instruction actually leaves EX.
          if (md.ex_advance) begin
            hilo_commit = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      a_raw_q    <= '0;
    end else begin
      if (div_start) begin
        q_neg_q    <= md.ex_mdsign & (md.ex_A[31] ^ md.ex_B[31]);
        r_neg_q    <= md.ex_mdsign & md.ex_A[31];
        div_zero_q <= (md.ex_B == 32'd0);
        a_raw_q    <= md.ex_A;
      end
      if (mul_load) begin
        {res_hi_q, res_lo_q} <= product;
      end
      if (div_finish) begin
        // Divide-by-zero result is fixed, independent of operand signs.
        if (div_zero_q) begin
          res_hi_q <= a_raw_q;
          res_lo_q <= MD_DIVZERO_LO;
        end else begin
          res_hi_q <= md_neg_if(div_rem, r_neg_q);
          res_lo_q <= md_neg_if(div_quo, q_neg_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_commit) begin
      hi_q <= res_hi_q;
      lo_q <= res_lo_q;
    end else if (mul_direct_wr) begin
      {hi_q, lo_q} <= product;
    end else if (mthilo_wr) begin
      if (md.ex_hilowen[1]) hi_q <= md.ex_A;
      if (md.ex_hilowen[0]) lo_q <= md.ex_A;
    end
  end

  assign md.hilo_rdata = md.ex_hiloren[1] ? hi_q :
                         md.ex_hiloren[0] ? lo_q : 32'd0;
  assign md.hi = hi_q;
  assign md.lo = lo_q;

endmodule
